// File: rtl/memory_stage.sv
// Memory stage: data-memory loads/stores over a req/ack bus, stalls upstream while busy.
// Optional access timeout with sticky mem_error when MEM_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module memory_stage #(
    parameter int ADDR_WIDTH = 11
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 15
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           alu_result_from_execute,
    input  logic                  reg_write_from_execute,
    input  logic [2:0]            reg_write_address_from_execute,
    input  logic [15:0]           sign_extend_from_execute,
    input  logic                  write_back_select_from_execute,
    input  logic [15:0]           reg_file_read_data1_from_execute,
    input  logic                  mem_read_from_execute,
    input  logic                  mem_write_from_execute,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic                  reg_write_to_wb,
    output logic [2:0]            reg_write_address_to_wb,
    output logic [15:0]           alu_result_to_wb,
    output logic [15:0]           mem_data_to_wb,
    output logic [15:0]           sign_extend_to_wb,
    output logic                  write_back_select_to_wb
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                  mem_error
`endif
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state;
    logic   access;
    logic   is_read;
    logic   in_access;
    logic   acked;
    logic   timeout;
    logic   done;
    logic   wb_load;

    assign access    = mem_read_from_execute | mem_write_from_execute;
    assign is_read   = mem_read_from_execute & ~mem_write_from_execute;
    assign in_access = (state == ACCESS);
    assign acked     = in_access & mem_ack;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cycle_count;

    assign timeout = in_access & ~mem_ack &
                     (cycle_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            mem_error   <= 1'b0;
        end else begin
            cycle_count <= in_access ? cycle_count + CW'(1) : '0;
            if (timeout)
                mem_error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign done    = acked | timeout;
    assign stall   = in_access ? ~done : access;
    // MEM/WB advances exactly when upstream is allowed to advance
    assign wb_load = ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access) begin
                        state     <= ACCESS;
                        mem_req   <= 1'b1;
                        mem_we    <= mem_write_from_execute;
                        mem_addr  <= alu_result_from_execute[ADDR_WIDTH-1:0];
                        mem_wdata <= reg_file_read_data1_from_execute;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_to_wb         <= 1'b0;
            reg_write_address_to_wb <= '0;
            alu_result_to_wb        <= '0;
            mem_data_to_wb          <= '0;
            sign_extend_to_wb       <= '0;
            write_back_select_to_wb <= 1'b0;
        end else if (wb_load) begin
            reg_write_to_wb         <= reg_write_from_execute & ~timeout;
            reg_write_address_to_wb <= reg_write_address_from_execute;
            alu_result_to_wb        <= alu_result_from_execute;
            mem_data_to_wb          <= (acked & is_read) ? mem_rdata : 16'h0;
            sign_extend_to_wb       <= sign_extend_from_execute;
            write_back_select_to_wb <= write_back_select_from_execute;
        end else begin
            reg_write_to_wb <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a MEM/WB scoreboard queue.
// Covers ALU pass-through, waited load, store, read+write, async reset, late ack.
`timescale 1ns/1ps
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] alu_result_from_execute = '0;
    logic        reg_write_from_execute = 1'b0;
    logic [2:0]  reg_write_address_from_execute = '0;
    logic [15:0] sign_extend_from_execute = '0;
    logic        write_back_select_from_execute = 1'b0;
    logic [15:0] reg_file_read_data1_from_execute = '0;
    logic        mem_read_from_execute = 1'b0;
    logic        mem_write_from_execute = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        reg_write_to_wb;
    logic [2:0]  reg_write_address_to_wb;
    logic [15:0] alu_result_to_wb;
    logic [15:0] mem_data_to_wb;
    logic [15:0] sign_extend_to_wb;
    logic        write_back_select_to_wb;
`ifdef MEM_TIMEOUT_EN
    logic        mem_error;
`endif

    memory_stage dut (
        .clk                              (clk),
        .reset                            (reset),
        .alu_result_from_execute          (alu_result_from_execute),
        .reg_write_from_execute           (reg_write_from_execute),
        .reg_write_address_from_execute   (reg_write_address_from_execute),
        .sign_extend_from_execute         (sign_extend_from_execute),
        .write_back_select_from_execute   (write_back_select_from_execute),
        .reg_file_read_data1_from_execute (reg_file_read_data1_from_execute),
        .mem_read_from_execute            (mem_read_from_execute),
        .mem_write_from_execute           (mem_write_from_execute),
        .stall                            (stall),
        .mem_req                          (mem_req),
        .mem_we                           (mem_we),
        .mem_addr                         (mem_addr),
        .mem_wdata                        (mem_wdata),
        .mem_rdata                        (mem_rdata),
        .mem_ack                          (mem_ack),
        .reg_write_to_wb                  (reg_write_to_wb),
        .reg_write_address_to_wb          (reg_write_address_to_wb),
        .alu_result_to_wb                 (alu_result_to_wb),
        .mem_data_to_wb                   (mem_data_to_wb),
        .sign_extend_to_wb                (sign_extend_to_wb),
        .write_back_select_to_wb          (write_back_select_to_wb)
`ifdef MEM_TIMEOUT_EN
        ,
        .mem_error                        (mem_error)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [2:0]  ra;
        logic [15:0] alu;
        logic [15:0] md;
        logic [15:0] se;
        logic        wbs;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic [2:0] ra,
                         input logic [15:0] alu, input logic [15:0] se,
                         input logic wbs, input logic [15:0] d1,
                         input logic rd, input logic wr);
        reg_write_from_execute           = rw;
        reg_write_address_from_execute   = ra;
        alu_result_from_execute          = alu;
        sign_extend_from_execute         = se;
        write_back_select_from_execute   = wbs;
        reg_file_read_data1_from_execute = d1;
        mem_read_from_execute            = rd;
        mem_write_from_execute           = wr;
    endtask

    task automatic push(input logic rw, input logic [2:0] ra,
                        input logic [15:0] alu, input logic [15:0] md,
                        input logic [15:0] se, input logic wbs);
        wb_t e;
        e.rw = rw; e.ra = ra; e.alu = alu;
        e.md = md; e.se = se; e.wbs = wbs;
        sb.push_back(e);
    endtask

    task automatic wb_check(input string tag);
        wb_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_rw"},  32'(reg_write_to_wb),         32'(e.rw));
            chk({tag, "_ra"},  32'(reg_write_address_to_wb), 32'(e.ra));
            chk({tag, "_alu"}, 32'(alu_result_to_wb),        32'(e.alu));
            chk({tag, "_md"},  32'(mem_data_to_wb),          32'(e.md));
            chk({tag, "_se"},  32'(sign_extend_to_wb),       32'(e.se));
            chk({tag, "_wbs"}, 32'(write_back_select_to_wb), 32'(e.wbs));
        end
    endtask

    // Runs one memory op already driven in IDLE; ack after `waits` ACCESS cycles.
    task automatic mem_op(input string tag, input logic [10:0] e_addr,
                          input logic e_we, input logic [15:0] e_wdata,
                          input int waits, input logic [15:0] rdata,
                          output int hi);
        hi = 0;
        #1 if (stall === 1'b1) hi++;
        tick();
        chk({tag, "_req"},    32'(mem_req),         32'd1);
        chk({tag, "_addr"},   32'(mem_addr),        32'(e_addr));
        chk({tag, "_we"},     32'(mem_we),          32'(e_we));
        chk({tag, "_wdata"},  32'(mem_wdata),       32'(e_wdata));
        chk({tag, "_bubble"}, 32'(reg_write_to_wb), 32'd0);
        for (int i = 0; i < waits; i++) begin
            #1 if (stall === 1'b1) hi++;
            tick();
            chk({tag, "_wait_req"},    32'(mem_req),         32'd1);
            chk({tag, "_wait_bubble"}, 32'(reg_write_to_wb), 32'd0);
        end
        mem_ack = 1'b1;
        mem_rdata = rdata;
        #1 if (stall === 1'b1) hi++;
        tick();
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        int hi;
        int n;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req",   32'(mem_req), 32'd0);
        chk("rst_we",    32'(mem_we), 32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
`ifdef MEM_TIMEOUT_EN
        chk("rst_err",   32'(mem_error), 32'd0);
`endif
        reset = 1'b1;
        push(0, 0, 0, 0, 0, 0);
        tick();
        wb_check("idle");

        drive(1, 3, 16'h1234, 16'h0055, 0, 16'h7777, 0, 0);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        push(1, 3, 16'h1234, 16'h0000, 16'h0055, 0);
        tick();
        wb_check("alu");
        chk("alu_req", 32'(mem_req), 32'd0);

        drive(1, 5, 16'h0025, 16'h0007, 1, 16'h3333, 1, 0);
        push(1, 5, 16'h0025, 16'hBEEF, 16'h0007, 1);
        mem_op("load", 11'h025, 1'b0, 16'h3333, 3, 16'hBEEF, hi);
        chk("load_stall_cycles", 32'(hi), 32'd4);
        wb_check("load");

        drive(0, 2, 16'h0010, 16'h0011, 0, 16'h00AA, 0, 1);
        push(0, 2, 16'h0010, 16'h0000, 16'h0011, 0);
        mem_op("store", 11'h010, 1'b1, 16'h00AA, 0, 16'h5555, hi);
        chk("store_stall_cycles", 32'(hi), 32'd1);
        wb_check("store");

        drive(1, 7, 16'hF808, 16'h0123, 1, 16'h4242, 1, 1);
        push(1, 7, 16'hF808, 16'h0000, 16'h0123, 1);
        mem_op("rdwr", 11'h008, 1'b1, 16'h4242, 1, 16'h1111, hi);
        chk("rdwr_stall_cycles", 32'(hi), 32'd2);
        wb_check("rdwr");

        drive(1, 4, 16'h0040, 16'h0000, 1, 16'h0000, 1, 0);
        tick();
        chk("rstmid_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 chk("rstmid_req_async", 32'(mem_req), 32'd0);
        chk("rstmid_rw", 32'(reg_write_to_wb), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;

        drive(1, 6, 16'hABCD, 16'h0099, 0, 16'h0000, 0, 0);
        push(1, 6, 16'hABCD, 16'h0000, 16'h0099, 0);
        tick();
        wb_check("post_rst_alu");
        push(1, 6, 16'hABCD, 16'h0000, 16'h0099, 0);
        mem_ack = 1'b1;
        mem_rdata = 16'hDEAD;
        #1 chk("late_ack_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        mem_rdata = 16'h0;
        wb_check("late_ack");
        chk("late_ack_req", 32'(mem_req), 32'd0);

`ifdef MEM_TIMEOUT_EN
        drive(1, 1, 16'h0077, 16'h0005, 1, 16'h0000, 1, 0);
        tick();
        n = 0;
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        chk("to_cycles", 32'(n), 32'd15);
        chk("to_req", 32'(mem_req), 32'd0);
        chk("to_err", 32'(mem_error), 32'd1);
        chk("to_rw", 32'(reg_write_to_wb), 32'd0);
        chk("to_alu", 32'(alu_result_to_wb), 32'h0077);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("to_late_ack_req", 32'(mem_req), 32'd0);
        chk("to_err_sticky", 32'(mem_error), 32'd1);
`else
        n = 0;
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the EX/MEM register outputs.
- Performs data-memory loads and stores through a req/ack handshake to an external data memory of variable latency.
- Stalls upstream while an access is outstanding and drives the MEM/WB pipeline register feeding write-back.

Parameters:
- ADDR_WIDTH, 11, data-memory word-address width; address = alu_result_from_execute[ADDR_WIDTH-1:0].
- TIMEOUT_CYCLES, 15, max ACCESS cycles before abort; only used with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_result_from_execute  in  16  ALU result; memory address for loads and stores.
- reg_write_from_execute  in  1  register-write enable.
- reg_write_address_from_execute  in  3  destination register.
- sign_extend_from_execute  in  16  sign-extended immediate.
- write_back_select_from_execute  in  1  1 = memory data, 0 = ALU result.
- reg_file_read_data1_from_execute  in  16  store data.
- mem_read_from_execute  in  1  load request.
- mem_write_from_execute  in  1  store request.
- stall  out  1  combinational; upstream holds EX/MEM contents while 1.
- mem_req  out  1  registered memory request.
- mem_we  out  1  registered; 1 = write.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_wdata  out  16  registered write data.
- mem_rdata  in  16  read data, valid when mem_ack = 1.
- mem_ack  in  1  one-cycle access-complete pulse.
- reg_write_to_wb  out  1  MEM/WB register-write enable.
- reg_write_address_to_wb  out  3  MEM/WB destination register.
- alu_result_to_wb  out  16  MEM/WB ALU result.
- mem_data_to_wb  out  16  MEM/WB load data.
- sign_extend_to_wb  out  16  MEM/WB immediate.
- write_back_select_to_wb  out  1  MEM/WB select.
- mem_error  out  1  sticky timeout flag; present only with MEM_TIMEOUT_EN.

Behaviour:
- Reset (reset = 0, async, any state, mid-access included):
  - State -> IDLE.
  - All registered outputs -> 0; mem_req drops immediately.
  - An outstanding access is abandoned.
  - A mem_ack after reset release while in IDLE is ignored.
- access = mem_read_from_execute | mem_write_from_execute. If both are set, the operation is a write: mem_we = 1, mem_data_to_wb = 0.
- IDLE:
  - access = 0: stall = 0; MEM/WB loads all inputs at the edge (1-cycle latency); mem_data_to_wb = 0.
  - access = 1: stall = 1; at the edge latch mem_addr, mem_wdata and mem_we, set mem_req = 1, go to ACCESS; MEM/WB loads a bubble (reg_write_to_wb = 0, other fields hold).
- ACCESS:
  - mem_req stays 1; bus outputs are stable.
  - mem_ack = 0: stall = 1; MEM/WB bubble.
  - mem_ack = 1: stall = 0. At the edge MEM/WB loads the held inputs; on a read, mem_data_to_wb = mem_rdata. mem_req -> 0, state -> IDLE.
  - Upstream advances on the same edge, so back-to-back accesses re-enter ACCESS after one IDLE cycle.
- Minimum occupancy of a memory instruction is 2 cycles (ack in the first ACCESS cycle). N wait cycles add N.
- Stores pass reg_write_from_execute through unchanged; the decoder normally drives 0 for stores.
- Address upper bits [15:ADDR_WIDTH] are ignored; there is no wrap logic.
- Upstream inputs are required to be stable while stall = 1 (execute-stage responsibility).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ACCESS.
  - If TIMEOUT_CYCLES cycles pass without mem_ack: mem_req -> 0, state -> IDLE, stall deasserts, MEM/WB loads the instruction with reg_write_to_wb forced to 0, and mem_error sets.
  - mem_error clears only on reset.
  - A late ack arriving in IDLE is ignored.
- Undefined: no counter and no mem_error port; ACCESS waits indefinitely.

Test Plan:
- Reset held low, then released with no access: all outputs 0. Then ALU op with alu_result = 0x1234, reg_write = 1, addr 3 -> next cycle reg_write_to_wb = 1, alu_result_to_wb = 0x1234, stall never rises.
- Load from 0x0025, ack after 3 wait cycles, mem_rdata = 0xBEEF -> mem_addr = 0x025, stall high 4 cycles, mem_data_to_wb = 0xBEEF after ack edge, bubbles in between.
- Store of data1 = 0x00AA to 0x0010, immediate ack -> mem_we = 1, mem_wdata = 0x00AA, stall high exactly 1 cycle.
- Reset asserted during ACCESS -> mem_req = 0 without waiting for clk. Later ack in IDLE -> no MEM/WB change.
- mem_read and mem_write both 1 -> write performed, mem_data_to_wb = 0.
- With MEM_TIMEOUT_EN, no ack -> after 15 ACCESS cycles mem_req = 0, mem_error = 1, reg_write_to_wb = 0.
